// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 keyboard receiver.
//   PS2_FRAME_BITS      - bits per device-to-host frame (start, 8 data, parity, stop)
//   PS2_START/PS2_STOP  - required levels of the start and stop bits
//   PS2_FIFO_DEPTH_DEF  - default scan-code buffer depth
//   PS2_TIMEOUT_DEF     - default mid-frame idle timeout in clk cycles
//   ps2_code_t          - one scan-code byte
package ps2_pkg;

    localparam int unsigned PS2_FRAME_BITS     = 11;
    localparam logic        PS2_START          = 1'b0;
    localparam logic        PS2_STOP           = 1'b1;
    localparam int unsigned PS2_FIFO_DEPTH_DEF = 8;
    localparam int unsigned PS2_TIMEOUT_DEF    = 5000;

    typedef logic [7:0] ps2_code_t;

endpackage

// File: rtl/ps2_keyboard_if.sv
// ps2_keyboard_if: scan-code delivery bus between the PS/2 receiver and its consumer.
//   nextdata_n - active-low pop request from the consumer
//   data       - scan code at the buffer head (show-ahead)
//   ready      - buffer non-empty
//   overflow   - sticky: a good frame was dropped because the buffer was full
//   frame_err  - one-cycle pulse on a rejected frame
// master: the receiver side; slave: the consumer side.
interface ps2_keyboard_if;
    import ps2_pkg::*;

    logic      nextdata_n;
    ps2_code_t data;
    logic      ready;
    logic      overflow;
    logic      frame_err;

    modport master (
        input  nextdata_n,
        output data,
        output ready,
        output overflow,
        output frame_err
    );

    modport slave (
        output nextdata_n,
        input  data,
        input  ready,
        input  overflow,
        input  frame_err
    );

endinterface

// File: rtl/ps2_sync_fifo.sv
// ps2_sync_fifo: pointer-based synchronous FIFO of scan codes with show-ahead read.
//   i_clk    - clock, rising edge
//   i_clrn   - synchronous active-low reset (pointers to 0)
//   i_push   - write request; accepted when not full, or when full and a pop is accepted
//   i_wdata  - byte to write
//   i_pop    - read request; ignored while empty
//   o_rdata  - head entry (8'h00 while empty)
//   o_full   - all DEPTH entries occupied
//   o_empty  - no entries held
module ps2_sync_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = PS2_FIFO_DEPTH_DEF
) (
    input  logic      i_clk,
    input  logic      i_clrn,
    input  logic      i_push,
    input  ps2_code_t i_wdata,
    input  logic      i_pop,
    output ps2_code_t o_rdata,
    output logic      o_full,
    output logic      o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // One extra pointer bit separates the full and empty cases when indices match.
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    ps2_code_t    r_mem [DEPTH];

    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;
    logic          w_pop_ok;
    logic          w_push_ok;

    assign w_wr_idx = r_wr_ptr[AW-1:0];
    assign w_rd_idx = r_rd_ptr[AW-1:0];

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (w_wr_idx == w_rd_idx) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

    // A pop in the same cycle frees the slot the push lands in.
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    assign o_rdata = o_empty ? '0 : r_mem[w_rd_idx];

    always_ff @(posedge i_clk) begin
        if (!i_clrn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[w_wr_idx] <= i_wdata;
    end

endmodule

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 device-to-host receiver feeding an 8-entry scan-code FIFO.
//   i_clk      - system clock, rising edge
//   i_clrn     - synchronous active-low reset
//   i_ps2_clk  - raw PS/2 clock pin (asynchronous)
//   i_ps2_data - raw PS/2 data pin (asynchronous)
//   io_kbd     - ps2_keyboard_if.master: nextdata_n in; data, ready, overflow, frame_err out
// Build option: define PS2_PARITY_CHECK_EN to make odd parity part of frame acceptance;
// otherwise only the start and stop bits are checked.
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = PS2_FIFO_DEPTH_DEF,
    parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_DEF
) (
    input  logic           i_clk,
    input  logic           i_clrn,
    input  logic           i_ps2_clk,
    input  logic           i_ps2_data,
    ps2_keyboard_if.master io_kbd
);

    localparam int unsigned TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]  LAST_BIT = 4'(PS2_FRAME_BITS - 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

    logic [2:0]    r_clk_sync;
    logic [1:0]    r_data_sync;
    logic [3:0]    r_cnt;
    logic [9:0]    r_buffer;      // the stop bit is checked live, never stored
    logic [TW-1:0] r_timeout;
    logic          r_frame_err;
    logic          r_overflow;

    logic      w_fall;
    logic      w_sample;
    logic      w_last;
    logic      w_start_ok;
    logic      w_stop_ok;
    logic      w_parity_ok;
    logic      w_good;
    logic      w_push;
    logic      w_pop;
    logic      w_full;
    logic      w_empty;
    ps2_code_t w_head;

    assign w_fall   = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_sample = r_data_sync[1];
    assign w_last   = w_fall && (r_cnt == LAST_BIT);

    assign w_start_ok = (r_buffer[0] == PS2_START);
    assign w_stop_ok  = (w_sample == PS2_STOP);
`ifdef PS2_PARITY_CHECK_EN
    assign w_parity_ok = ^r_buffer[9:1];
`else
    logic w_unused_parity;
    assign w_unused_parity = r_buffer[9];
    assign w_parity_ok     = 1'b1;
`endif
    assign w_good = w_start_ok & w_stop_ok & w_parity_ok;
    assign w_push = w_last & w_good;
    assign w_pop  = ~io_kbd.nextdata_n & ~w_empty;

    always_ff @(posedge i_clk) begin
        if (!i_clrn) begin
            r_clk_sync  <= 3'b111;
            r_data_sync <= 2'b11;
            r_cnt       <= '0;
            r_buffer    <= '0;
            r_timeout   <= '0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[1:0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
            r_frame_err <= w_last & ~w_good;

            // Full FIFO with no concurrent pop: the byte is lost.
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;

            if (w_fall) begin
                r_timeout <= '0;
                if (r_cnt == LAST_BIT) begin
                    r_cnt <= '0;
                end else begin
                    r_buffer[r_cnt] <= w_sample;
                    r_cnt           <= r_cnt + 4'd1;
                end
            end else if (r_cnt != 4'd0) begin
                // Abandon a stalled partial frame so the next one aligns.
                if (r_timeout == TO_MAX) begin
                    r_cnt     <= '0;
                    r_timeout <= '0;
                end else begin
                    r_timeout <= r_timeout + TW'(1);
                end
            end else begin
                r_timeout <= '0;
            end
        end
    end

    ps2_sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_clrn  (i_clrn),
        .i_push  (w_push),
        .i_wdata (r_buffer[8:1]),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign io_kbd.data      = w_head;
    assign io_kbd.ready     = ~w_empty;
    assign io_kbd.overflow  = r_overflow;
    assign io_kbd.frame_err = r_frame_err;

endmodule

// File: doc/ps2_keyboard.md
# ps2_keyboard

PS/2 keyboard receiver that deserialises 11-bit device-to-host frames into 8-bit scan codes and buffers them in an 8-entry FIFO. It sits directly upstream of the scan-code/BCD decode and 7-segment display path and feeds it one byte at a time through a ready/pop handshake. The raw `ps2_clk`/`ps2_data` pins come from the board and are asynchronous to `clk`.

## Interface
- `FIFO_DEPTH`, 8: buffer entries; must be a power of two, minimum 2.
- `TIMEOUT_CYCLES`, 5000: idle `clk` cycles mid-frame before the bit counter is abandoned; minimum 16.
- `clk` input 1: system clock; all logic is on its rising edge.
- `clrn` input 1: synchronous, active-low reset.
- `ps2_clk` input 1: raw PS/2 clock, asynchronous.
- `ps2_data` input 1: raw PS/2 data, asynchronous.
- `nextdata_n` input 1: active-low pop request, sampled each `clk`.
- `data` output 8: scan code at the FIFO head; this is a show-ahead read.
- `ready` output 1: FIFO non-empty.
- `overflow` output 1: sticky; a good frame arrived while the FIFO was full.
- `frame_err` output 1: one-cycle pulse when a completed frame fails a check.

## Operation
- Reset (`clrn`=0 at a rising edge) clears the following:
  - synchroniser history to 3'b111;
  - bit counter to 0 and shift buffer to 0;
  - FIFO pointers to 0 and the timeout counter to 0;
  - `ready`=0, `data`=8'h00, `overflow`=0, `frame_err`=0.
- Synchroniser: a 3-flop shift register on `ps2_clk` and a 2-flop on `ps2_data`. A falling edge is detected when the two oldest clock samples are 1 then 0.
- Receive states, encoded as a bit counter `cnt` from 0 to 10:
  - On each detected falling edge, store synced data into `buffer[cnt]`.
  - If `cnt`<10, increment `cnt`. If `cnt`==10, evaluate the frame and return `cnt` to 0.
- Frame checks are start bit `buffer[0]`==0, stop bit (the current sample)==1, and odd parity over `buffer[9:1]`.
  - Good frame: push `buffer[8:1]`, LSB first on the wire.
  - Failed frame: discard it and pulse `frame_err`.
- Timeout: this counter runs while `cnt`≠0 and clears on every falling edge. When it reaches `TIMEOUT_CYCLES`, `cnt` goes to 0 with no push and no `frame_err`.
- FIFO behaviour:
  - Read and write pointers are log2(`FIFO_DEPTH`)+1 bits wide, so full and empty can be distinguished. Both wrap modulo 2×`FIFO_DEPTH`.
  - Empty: pointers are equal. Full: the indices are equal and the MSBs differ.
- Pop: `nextdata_n`=0 and `ready`=1 advance the read pointer. A pop while empty is ignored.
- Push while full: the byte is dropped, the FIFO is unchanged and `overflow` is set. `overflow` clears only on reset.
- Simultaneous push and pop: both occur in the same cycle and the occupancy is unchanged. When the FIFO is full, the pop frees a slot in that same cycle, so the push succeeds and `overflow` is not set.

## Timing
- Falling-edge detection lags the pin by 2–3 `clk` cycles (synchroniser).
- The push takes effect at the `clk` edge that samples the 11th falling edge. `ready` and `data` update on the following cycle, with `data` available from a registered pointer and a combinational array read.
- A pop takes effect at the sampling edge. The next entry appears on `data` one cycle later, and `ready` drops in that same cycle when the FIFO becomes empty.
- `frame_err` is high for exactly the one cycle after the 11th edge.
- The PS/2 clock is 10–16.7 kHz and `clk` is at least 1 MHz, so the FIFO can accept a push on every frame.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: the odd-parity check is part of frame acceptance as described above.
- `PS2_PARITY_CHECK_EN` undefined: parity is ignored. Only the start and stop bits gate the push, and `frame_err` fires only on start/stop failure.

## Structure
- Shared package `ps2_pkg` holds:
  - frame constants: `PS2_FRAME_BITS`=11, `PS2_START`=0, `PS2_STOP`=1;
  - the default `FIFO_DEPTH` and `TIMEOUT_CYCLES`;
  - a `ps2_code_t` 8-bit typedef.
- One sub-module, `ps2_sync_fifo`: a parameterised pointer FIFO with push/pop/full/empty. The top level owns the synchroniser, receive counter, checks and timeout.

## Test plan
- Reset, then send frame 0x1C (start 0, data 00111000 LSB-first, parity 0, stop 1). Expect `ready`=1 and `data`=8'h1C; after a pop, `ready`=0.
- Send 0x1C with parity bit 1 (macro on). Expect a single `frame_err` pulse, `ready` stays 0 and the FIFO stays empty. With the macro off, expect 0x1C to be pushed.
- Send 9 frames 0x01–0x09 with no pops. Expect `overflow`=1, and pops must return 0x01–0x08 in order, then `ready`=0.
- With 8 entries held, pop in the cycle the 9th frame completes. Expect no overflow, and the FIFO still holds 8 entries with the 9th byte last.
- Send 5 bits, then idle for `TIMEOUT_CYCLES`+1 cycles, then send a full 0xF0 frame. Expect only 0xF0 pushed and no `frame_err`.
- Pull `clrn` low for one cycle after 6 bits and with 3 entries queued. Expect `ready`=0, `data`=0, `overflow`=0; a following 0x5A frame is received correctly.
